// File: rtl/fake_entropy_stream.sv
// rtl/fake_entropy_stream.sv - simulation-only LFSR fake entropy source with FIFO and syn/ack delivery; FAKE_ENTROPY_FAULT_EN enables stuck-zero injection
module fake_entropy_stream #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(32'h00400007),
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED  = DATA_WIDTH'(32'h00000001),
  parameter int                    RATE_DIV   = 4,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fault_inject,
  output logic [DATA_WIDTH-1:0] raw_entropy,
  output logic [31:0]           stats,
  output logic                  enabled,
  output logic                  entropy_syn,
  output logic [DATA_WIDTH-1:0] entropy_data,
  input  logic                  entropy_ack
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [DATA_WIDTH-1:0] SEED_EFF   = (LFSR_SEED == '0) ? DATA_WIDTH'(1) : LFSR_SEED;
  localparam logic [CW-1:0]         RATE_LAST  = CW'(RATE_DIV - 1);
  localparam logic [AW:0]           COUNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]           COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]         PTR_ONE    = AW'(1);
  localparam logic [15:0]           SAT_MAX    = 16'hFFFF;

  logic [DATA_WIDTH-1:0] lfsr;
  logic [DATA_WIDTH-1:0] lfsr_next;
  logic [DATA_WIDTH-1:0] push_word;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [CW-1:0]         rate_cnt;
  logic [15:0]           delivered;
  logic [15:0]           dropped;
  logic                  tick;
  logic                  full;
  logic                  syn;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // LFSR step and the per-cycle push/pop/drop decisions.
  always_comb begin
    lfsr_next = {lfsr[DATA_WIDTH-2:0], 1'b0} ^ (lfsr[DATA_WIDTH-1] ? LFSR_TAPS : '0);
    tick      = enable && (rate_cnt == RATE_LAST);
    full      = (count == COUNT_FULL);
    syn       = enable && (count != '0);
    pop       = syn && entropy_ack;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    push      = tick && (!full || pop);
    drop      = tick && full && !pop;
  end

`ifdef FAKE_ENTROPY_FAULT_EN
  // Stuck-at-zero words while a fault is requested; the LFSR itself keeps running.
  always_comb begin
    push_word = fault_inject ? '0 : lfsr;
  end
`else
  logic unused_fault_inject;

  // Fault injection is not built in this configuration; the port is only tied off.
  always_comb begin
    push_word           = lfsr;
    unused_fault_inject = fault_inject;
  end
`endif

  // FIFO storage; pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // LFSR, rate counter, FIFO bookkeeping and saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= SEED_EFF;
      rate_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      delivered <= '0;
      dropped   <= '0;
      enabled   <= 1'b0;
    end else begin
      enabled <= enable;
      if (!enable) begin
        // Stopping flushes buffered words; LFSR and statistics are kept.
        rate_cnt <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        lfsr     <= lfsr_next;
        rate_cnt <= tick ? '0 : rate_cnt + CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({push, pop})
          2'b10:   count <= count + COUNT_ONE;
          2'b01:   count <= count - COUNT_ONE;
          default: count <= count;
        endcase
        if (pop && (delivered != SAT_MAX)) begin
          delivered <= delivered + 16'd1;
        end
        if (drop && (dropped != SAT_MAX)) begin
          dropped <= dropped + 16'd1;
        end
      end
    end
  end

  assign raw_entropy  = enable ? lfsr : '0;
  assign entropy_syn  = syn;
  assign entropy_data = syn ? mem[rd_ptr] : '0;
  assign stats        = {delivered, dropped};

endmodule
